// File: rtl/buffer_pkg.sv
// rtl/buffer_pkg.sv - shared types and pointer helpers for buffer blocks
//
// Contents:
//   loop_fifo_mode_e : read-port mode (MODE_FIFO consumes, MODE_LOOP replays)
//   ptr_next         : advance a ring pointer inside the window [base, base+len-1]
package buffer_pkg;

  typedef enum logic {
    MODE_FIFO = 1'b0,
    MODE_LOOP = 1'b1
  } loop_fifo_mode_e;

  // Advance ptr by one. It wraps back to base after the last element of the
  // window (base + len - 1). The arithmetic is modulo (mask + 1), and mask is
  // DEPTH - 1 of the caller's ring. The caller narrows the result to its
  // pointer width. len must be non-zero.
  function automatic logic [31:0] ptr_next(input logic [31:0] ptr,
                                           input logic [31:0] base,
                                           input logic [31:0] len,
                                           input logic [31:0] mask);
    logic [31:0] last;
    last = (base + len - 32'd1) & mask;
    if ((ptr & mask) == last) begin
      return base & mask;
    end
    return (ptr + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/loop_fifo_ring_mem.sv
// rtl/loop_fifo_ring_mem.sv - DEPTH x DATA_WIDTH storage, sync write, async read
//
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write word
//   raddr : read address
//   rdata : combinational read word at raddr (contents before this edge's write)
module ring_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Storage has no reset, so it maps onto plain RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/loop_fifo.sv
// rtl/loop_fifo.sv - word buffer with FIFO and cyclic LOOP playback read modes
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous flush, overrides every other input
//   loop_mode   : 0 = FIFO (reads consume), 1 = LOOP (reads replay stored words)
//   wr_valid/wr_ready/wr_data : write port, wr_ready = !full
//   rd_valid/rd_ready/rd_data : registered read port
//   count, empty, full        : occupancy
//   overflow    : sticky flag, set when a write is attempted while full
//   wr_ptr_dbg  : tail pointer
//   rd_ptr_dbg  : address of the presented entry
module loop_fifo
  import buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  loop_mode,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] wr_ptr_dbg,
  output logic [ADDR_WIDTH-1:0] rd_ptr_dbg
);

  localparam int          CW       = ADDR_WIDTH + 1;
  localparam logic [31:0] PTR_MASK = 32'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] head, tail, play;
  logic [CW-1:0]         count_q;
  loop_fifo_mode_e       mode_q, mode_in;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  overflow_q;

  logic                  wr_fire, hs, pop, adv, mode_change, avail, load;
  logic [ADDR_WIDTH-1:0] head_n, tail_n, play_n, rd_addr_n;
  logic [CW-1:0]         count_after_pop, count_n;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign mode_in     = loop_fifo_mode_e'(loop_mode);
  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign wr_ready    = !full;

  assign wr_fire     = wr_valid && !full;
  assign hs          = rd_valid_q && rd_ready;
  // A handshake always completes under the registered mode. This also holds
  // on the edge where loop_mode changes.
  assign pop         = hs && (mode_q == MODE_FIFO);
  assign adv         = hs && (mode_q == MODE_LOOP);
  assign mode_change = (mode_in != mode_q);

  always_comb begin
    head_n          = pop ? head + ADDR_WIDTH'(1) : head;
    tail_n          = wr_fire ? tail + ADDR_WIDTH'(1) : tail;
    count_after_pop = pop ? count_q - CW'(1) : count_q;
    count_n         = count_after_pop + CW'(wr_fire);

    // The loop window uses count from before this edge's write. A word that
    // lands on the wrapping edge therefore joins the next lap.
    play_n = play;
    if (mode_change) begin
      play_n = head_n;
    end else if (adv) begin
      play_n = ADDR_WIDTH'(ptr_next(32'(play), 32'(head), 32'(count_q), PTR_MASK));
    end

    rd_addr_n = (mode_q == MODE_LOOP) ? play_n : head_n;

    // The output register only loads words already in memory. A word written
    // on this edge becomes visible one edge later.
    avail = (count_after_pop != '0);
    load  = !rd_valid_q || rd_ready;
  end

  ring_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_fire && !clear),
    .waddr(tail),
    .wdata(wr_data),
    .raddr(rd_addr_n),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      play       <= '0;
      count_q    <= '0;
      mode_q     <= MODE_FIFO;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      head       <= '0;
      tail       <= '0;
      play       <= '0;
      count_q    <= '0;
      mode_q     <= mode_in;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      head    <= head_n;
      tail    <= tail_n;
      play    <= play_n;
      count_q <= count_n;
      mode_q  <= mode_in;
      if (wr_valid && full) begin
        overflow_q <= 1'b1;
      end
      // A mode switch inserts one bubble. The entry at head is then presented.
      if (mode_change) begin
        rd_valid_q <= 1'b0;
      end else if (load) begin
        rd_valid_q <= avail;
        if (avail) begin
          rd_data_q <= mem_rdata;
        end
      end
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign wr_ptr_dbg = tail;
  assign rd_ptr_dbg = (mode_q == MODE_LOOP) ? play : head;

endmodule

// File: tb/tb_loop_fifo.sv
// tb/tb_loop_fifo.sv - self-checking bench for loop_fifo (DEPTH=8, DATA_WIDTH=8)
module tb_loop_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          loop_mode = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          empty, full, overflow;
  logic [AW-1:0] wr_ptr_dbg, rd_ptr_dbg;

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_w;

  loop_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .loop_mode(loop_mode),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .empty(empty), .full(full), .overflow(overflow),
    .wr_ptr_dbg(wr_ptr_dbg), .rd_ptr_dbg(rd_ptr_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset;
    #22;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset rd_valid: got %b want 0", rd_valid); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0 || wr_ready !== 1'b1) begin failures++; $display("FAIL reset flags: empty=%b full=%b wr_ready=%b want 1 0 1", empty, full, wr_ready); end
    checks++; if (rd_data !== 8'h00 || overflow !== 1'b0) begin failures++; $display("FAIL reset data/overflow: rd_data=%h overflow=%b want 00 0", rd_data, overflow); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fifo_order;
    logic [DW-1:0] v [3];
    int first_valid;
    v = '{8'h11, 8'h22, 8'h33};
    sb.delete();
    first_valid = -1;
    rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i < 3) begin
        wr_valid = 1'b1; wr_data = v[i]; sb.push_back(v[i]);
      end else begin
        wr_valid = 1'b0;
      end
      if (rd_valid && first_valid < 0) first_valid = i;
      if (rd_valid && rd_ready) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL fifo_order extra word: got %h want none", rd_data); end
        else begin
          exp_w = sb.pop_front();
          if (rd_data !== exp_w) begin failures++; $display("FAIL fifo_order data: got %h want %h", rd_data, exp_w); end
        end
      end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (first_valid != 2) begin failures++; $display("FAIL fifo_order latency: rd_valid first at cycle %0d want 2", first_valid); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL fifo_order drained: %0d words left want 0", sb.size()); end
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin failures++; $display("FAIL fifo_order end: count=%0d empty=%b want 0 1", count, empty); end
  endtask

  task automatic test_fill_overflow;
    logic seen99;
    sb.delete();
    seen99 = 1'b0;
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_data = 8'h40 + 8'(i); sb.push_back(8'h40 + 8'(i));
      tick();
    end
    wr_valid = 1'b0;
    checks++; if (full !== 1'b1 || wr_ready !== 1'b0 || count !== 4'd8) begin failures++; $display("FAIL fill: full=%b wr_ready=%b count=%0d want 1 0 8", full, wr_ready, count); end
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h40) begin failures++; $display("FAIL fill hold: rd_valid=%b rd_data=%h want 1 40", rd_valid, rd_data); end
    wr_valid = 1'b1; wr_data = 8'h99;
    tick();
    wr_valid = 1'b0;
    checks++; if (overflow !== 1'b1 || count !== 4'd8) begin failures++; $display("FAIL overflow: overflow=%b count=%0d want 1 8", overflow, count); end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (rd_valid && rd_ready) begin
        checks++;
        if (rd_data === 8'h99) seen99 = 1'b1;
        if (sb.size() == 0) begin failures++; $display("FAIL fill_drain extra word: got %h want none", rd_data); end
        else begin
          exp_w = sb.pop_front();
          if (rd_data !== exp_w) begin failures++; $display("FAIL fill_drain data: got %h want %h", rd_data, exp_w); end
        end
      end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (sb.size() != 0 || seen99) begin failures++; $display("FAIL fill_drain end: left=%0d seen99=%b want 0 0", sb.size(), seen99); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow sticky: got %b want 1", overflow); end
    wr_valid = 1'b1; wr_data = 8'h01; tick();
    wr_data = 8'h02; tick();
    clear = 1'b1; wr_data = 8'h03;
    tick();
    clear = 1'b0; wr_valid = 1'b0;
    checks++; if (count !== 4'd0 || overflow !== 1'b0 || rd_valid !== 1'b0 || wr_ptr_dbg !== 3'd0) begin failures++; $display("FAIL clear: count=%0d overflow=%b rd_valid=%b wr_ptr=%0d want 0 0 0 0", count, overflow, rd_valid, wr_ptr_dbg); end
  endtask

  task automatic test_loop_replay;
    logic [DW-1:0] seq [13];
    seq = '{8'hA1, 8'hB2, 8'hC3, 8'hA1, 8'hB2, 8'hC3, 8'hA1,
            8'hB2, 8'hC3, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    sb.delete();
    loop_mode = 1'b1;
    tick(); tick();
    rd_ready = 1'b0;
    wr_valid = 1'b1; wr_data = 8'hA1; tick();
    wr_data = 8'hB2; tick();
    wr_data = 8'hC3; tick();
    wr_valid = 1'b0;
    tick();
    for (int i = 0; i < 13; i++) sb.push_back(seq[i]);
    rd_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i == 8) begin wr_valid = 1'b1; wr_data = 8'hD4; end
      else wr_valid = 1'b0;
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL loop bubble at read %0d: rd_valid=%b want 1", i, rd_valid); end
      if (rd_valid && rd_ready) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL loop extra word: got %h want none", rd_data); end
        else begin
          exp_w = sb.pop_front();
          if (rd_data !== exp_w) begin failures++; $display("FAIL loop data at read %0d: got %h want %h", i, rd_data, exp_w); end
        end
      end
      if (i == 6) begin
        checks++; if (count !== 4'd3) begin failures++; $display("FAIL loop count: got %0d want 3", count); end
      end
      tick();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    checks++; if (count !== 4'd4 || sb.size() != 0) begin failures++; $display("FAIL loop end: count=%0d left=%0d want 4 0", count, sb.size()); end
  endtask

  task automatic test_loop_single;
    sb.delete();
    do_clear();
    rd_ready = 1'b0;
    wr_valid = 1'b1; wr_data = 8'h5A; tick();
    wr_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) sb.push_back(8'h5A);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL loop_single bubble at %0d: rd_valid=%b want 1", i, rd_valid); end
      if (rd_valid && rd_ready) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL loop_single extra word: got %h want none", rd_data); end
        else begin
          exp_w = sb.pop_front();
          if (rd_data !== exp_w) begin failures++; $display("FAIL loop_single data: got %h want %h", rd_data, exp_w); end
        end
      end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (count !== 4'd1 || sb.size() != 0) begin failures++; $display("FAIL loop_single end: count=%0d left=%0d want 1 0", count, sb.size()); end
  endtask

  task automatic test_mode_switch;
    sb.delete();
    do_clear();
    rd_ready = 1'b0;
    wr_valid = 1'b1; wr_data = 8'hA1; tick();
    wr_data = 8'hB2; tick();
    wr_data = 8'hC3; tick();
    wr_valid = 1'b0;
    tick(); tick();
    sb.push_back(8'hA1); sb.push_back(8'hB2);
    sb.push_back(8'hA1); sb.push_back(8'hB2); sb.push_back(8'hC3);
    rd_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) loop_mode = 1'b0;
      if (i == 2) begin
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL mode_switch bubble: rd_valid=%b want 0", rd_valid); end
      end
      if (rd_valid && rd_ready) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL mode_switch extra word: got %h want none", rd_data); end
        else begin
          exp_w = sb.pop_front();
          if (rd_data !== exp_w) begin failures++; $display("FAIL mode_switch data at %0d: got %h want %h", i, rd_data, exp_w); end
        end
      end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (sb.size() != 0 || count !== 4'd0 || empty !== 1'b1) begin failures++; $display("FAIL mode_switch end: left=%0d count=%0d empty=%b want 0 0 1", sb.size(), count, empty); end
  endtask

  task automatic test_async_reset;
    rd_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = 8'h70 + 8'(i); tick();
    end
    wr_valid = 1'b0;
    tick();
    checks++; if (count !== 4'd5 || rd_valid !== 1'b1) begin failures++; $display("FAIL async_reset setup: count=%0d rd_valid=%b want 5 1", count, rd_valid); end
    rd_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0) begin failures++; $display("FAIL async_reset state: rd_valid=%b count=%0d overflow=%b want 0 0 0", rd_valid, count, overflow); end
    checks++; if (wr_ptr_dbg !== 3'd0 || rd_ptr_dbg !== 3'd0) begin failures++; $display("FAIL async_reset ptrs: wr=%0d rd=%0d want 0 0", wr_ptr_dbg, rd_ptr_dbg); end
    rd_ready = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    checks++; if (wr_ready !== 1'b1 || empty !== 1'b1) begin failures++; $display("FAIL async_reset release: wr_ready=%b empty=%b want 1 1", wr_ready, empty); end
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_fill_overflow();
    test_loop_replay();
    test_loop_single();
    test_mode_switch();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
